// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXECUTE/MEM/WB over a
// shared-ALU, single-memory datapath with a mem_ready timeout and illegal-op handling.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT     = 15,
  parameter bit HALT_ON_ILLEGAL = 1'b1,
  parameter int STATE_W         = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7_5,
  input  logic               zero,
  input  logic               lt,
  input  logic               ltu,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               adr_src,
  output logic               ir_write,
  output logic               pc_write,
  output logic               reg_write,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [3:0]         alu_control,
  output logic [1:0]         result_src,
  output logic [2:0]         imm_src,
  output logic [1:0]         store_size,
  output logic [2:0]         load_type,
  output logic               illegal_instr,
  output logic               mem_fault,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R, S_EXEC_I,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC, S_HALT, S_FAULT
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1;
  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4;

  state_t     state, state_n;
  logic [7:0] wait_cnt;
  logic       illegal, timeout;

  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'b000:  alu_dec = (is_r && f7) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_dec = 4'd7;
      3'b010:  alu_dec = 4'd5;
      3'b011:  alu_dec = 4'd6;
      3'b100:  alu_dec = 4'd4;
      3'b101:  alu_dec = f7 ? 4'd9 : 4'd8;
      3'b110:  alu_dec = 4'd3;
      default: alu_dec = 4'd2;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_FETCH;
      wait_cnt      <= '0;
      mem_fault     <= 1'b0;
      illegal_instr <= 1'b0;
    end else begin
      state         <= state_n;
      illegal_instr <= illegal;
      if (state_n == S_FAULT) mem_fault <= 1'b1;
      if (mem_req && !mem_ready && state_n == state) wait_cnt <= wait_cnt + 8'd1;
      else                                           wait_cnt <= '0;
    end
  end

  always_comb begin
    state_n     = state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    result_src  = 2'b00;
    imm_src     = IMM_I;
    store_size  = 2'b00;
    load_type   = 3'b000;
    illegal     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_n  = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALUOut gets oldPC+imm: branch target, or the JAL target when op is JAL
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = (op == 7'b1101111) ? IMM_J : IMM_B;
        case (op)
          7'b0000011, 7'b0100011: state_n = S_MEMADR;
          7'b0110011:             state_n = S_EXEC_R;
          7'b0010011:             state_n = S_EXEC_I;
          7'b1100011:             state_n = S_BRANCH;
          7'b1101111:             state_n = S_JAL;
          7'b1100111:             state_n = S_JALR;
          7'b0110111:             state_n = S_LUI;
          7'b0010111:             state_n = S_AUIPC;
          default:                illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = op[5] ? IMM_S : IMM_I;
        if (op[5]) begin
          if (funct3[2] || funct3[1:0] == 2'b11) illegal = 1'b1;
          else                                   state_n = S_MEMWRITE;
        end else begin
          if (funct3 == 3'b011 || funct3[2:1] == 2'b11) illegal = 1'b1;
          else                                          state_n = S_MEMREAD;
        end
      end
      S_MEMREAD, S_MEMWRITE: begin
        mem_req    = 1'b1;
        adr_src    = 1'b1;
        mem_we     = (state == S_MEMWRITE);
        store_size = funct3[1:0];
        load_type  = funct3;
        if (mem_ready) state_n = (state == S_MEMREAD) ? S_MEMWB : S_FETCH;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        result_src = 2'b01;
        state_n    = S_FETCH;
      end
      S_EXEC_R, S_EXEC_I: begin
        alu_src_a   = 2'b10;
        alu_src_b   = (state == S_EXEC_I) ? 2'b01 : 2'b00;
        alu_control = alu_dec(funct3, funct7_5, state == S_EXEC_R);
        state_n     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_n   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        state_n     = S_FETCH;
        case (funct3)
          3'b000:  pc_write = zero;
          3'b001:  pc_write = ~zero;
          3'b100:  pc_write = lt;
          3'b101:  pc_write = ~lt;
          3'b110:  pc_write = ltu;
          3'b111:  pc_write = ~ltu;
          default: illegal  = 1'b1;
        endcase
      end
      S_JAL: begin
        // Jump from ALUOut while the ALU forms the link value oldPC+4
        pc_write  = 1'b1;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_n   = S_ALUWB;
      end
      S_JALR: begin
        // rs1+imm lands in ALUOut; the JAL state then jumps there and links
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_n   = S_JAL;
      end
      S_LUI: begin
        alu_src_a  = 2'b11;  // zero operand
        alu_src_b  = 2'b01;
        imm_src    = IMM_U;
        reg_write  = 1'b1;
        result_src = 2'b10;
        state_n    = S_FETCH;
      end
      S_AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = IMM_U;
        state_n   = S_ALUWB;
      end
      default: ;  // HALT and FAULT hold until rst
    endcase

    if (illegal) state_n = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
    timeout = mem_req && !mem_ready && (wait_cnt == 8'(MEM_TIMEOUT - 1));
    if (timeout) state_n = S_FAULT;

    // No strobe escapes while reset is held, even mid-transfer
    if (rst) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign state_o = STATE_W'(state);

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle RV32I control unit; successor to the single-cycle combinational decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB states and drives a shared-ALU, single-memory datapath.
- Adds features the single-cycle decoder lacks:
  - memory ready handshake with a timeout;
  - signed/unsigned branch evaluation from dedicated flags;
  - correct AUIPC decode;
  - an illegal-instruction mode.

Parameters:
MEM_TIMEOUT, 15, max cycles mem_req may wait for mem_ready before fault (1..255)
HALT_ON_ILLEGAL, 1, 1: illegal opcode enters HALT; 0: pulse illegal_instr and resume FETCH
STATE_W, 4, width of state_o debug port

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
op  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7_5  in  1  IR[30]
zero  in  1  ALU result == 0
lt  in  1  signed rs1 < rs2
ltu  in  1  unsigned rs1 < rs2
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory access request
mem_we  out  1  write when mem_req=1
adr_src  out  1  0=PC, 1=ALUOut
ir_write  out  1  latch IR and oldPC
pc_write  out  1  update PC from result bus
reg_write  out  1  register file write
alu_src_a  out  2  00=PC, 01=oldPC, 10=rs1
alu_src_b  out  2  00=rs2, 01=imm, 10=const 4
alu_control  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA
result_src  out  2  00=ALUOut, 01=MemData, 10=ALU result
imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U
store_size  out  2  00 byte, 01 half, 10 word
load_type  out  3  funct3 of load (LB/LH/LW/LBU/LHU)
illegal_instr  out  1  one-cycle pulse on illegal decode
mem_fault  out  1  sticky; set on timeout
state_o  out  STATE_W  current state encoding

Behaviour:
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC_R=6, EXEC_I=7, ALUWB=8
  - BRANCH=9, JAL=10, JALR=11, LUI=12, AUIPC=13, HALT=14, FAULT=15
- Reset: state=FETCH, timeout counter=0, mem_fault=0, illegal_instr=0.
- Combinational strobes (mem_req, mem_we, ir_write, pc_write, reg_write) are 0 unless a state below asserts them. Muxes default to 0.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, ADD, result_src=10.
  - ir_write and pc_write are asserted only in the cycle mem_ready=1; the FSM then goes to DECODE.
  - Otherwise the FSM stays in FETCH.
- DECODE: alu_src_a=01, alu_src_b=01, imm_src=B, ADD (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - any other op → illegal
- MEMADR: rs1+imm (imm_src I for loads, S for stores). Next MEMREAD for loads, MEMWRITE for stores.
  - Store funct3 ∉ {000,001,010} → illegal.
  - Load funct3 ∉ {000,001,010,100,101} → illegal.
- MEMREAD/MEMWRITE: mem_req=1, adr_src=1, mem_we=1 in MEMWRITE only. store_size=funct3[1:0]; load_type=funct3.
  - The FSM stays in the state until mem_ready.
  - Then MEMREAD → MEMWB (reg_write=1, result_src=01) → FETCH, and MEMWRITE → FETCH.
- EXEC_R / EXEC_I: ALU op from funct3.
  - SUB only for R-type with funct7_5=1; SRA when funct3=101 and funct7_5=1.
  - Next ALUWB: reg_write=1, result_src=00, then FETCH.
- BRANCH: SUB on rs1/rs2. Taken condition by funct3:
  - 000 zero; 001 ~zero; 100 lt; 101 ~lt; 110 ltu; 111 ~ltu
  - 010/011 → illegal
  - If taken: pc_write=1, result_src=00. Next FETCH.
- JAL: pc_write=1 from ALUOut (imm_src J computed in DECODE); oldPC+4 written back via ALUWB path, then FETCH.
- JALR: target = rs1+imm, then pc_write; link oldPC+4 via ALUWB, then FETCH.
- LUI: imm_src U, reg_write, result_src=10 with alu_src_b=01 and a zero operand, then FETCH.
- AUIPC: oldPC+imm U via ALUWB, then FETCH.
- Illegal: illegal_instr pulses for one cycle.
  - HALT_ON_ILLEGAL=1 → HALT, which holds until rst.
  - HALT_ON_ILLEGAL=0 → FETCH (PC already advanced).
- Timeout: the counter increments each cycle mem_req=1 && !mem_ready and clears on mem_ready or a state change.
  - When the counter reaches MEM_TIMEOUT: FAULT, mem_fault=1, all strobes 0. FAULT holds until rst.
- rst has priority over all transitions, including a mid-transfer mem_req or mem_ready arriving in the same cycle.

Test Plan:
- ADD x3,x1,x2 with mem_ready tied 1 → states 0,1,6,8,0; reg_write high only in ALUWB; alu_control=0000; SUB variant gives 0001.
- LW with mem_ready delayed 3 cycles in FETCH and MEMREAD → ir_write single cycle on ready; load completes in 5+6 cycles; result_src=01 at MEMWB.
- BLT with lt=1 → pc_write=1 in BRANCH; BGEU with ltu=1 → pc_write=0; funct3=010 → illegal_instr pulse.
- op=0000000 with HALT_ON_ILLEGAL=1 → state 14 held for 20 cycles; with 0 → back to FETCH next cycle.
- FETCH with mem_ready never asserted → state 15 after 15 wait cycles; mem_fault=1 sticky until rst.
- rst asserted during MEMWRITE wait → next cycle state=0, mem_req=0 until FETCH re-issues.
